// File: rtl/mii_hex_streamer.sv
// Captures bytes from an MII receive core into a FIFO and streams them to a UART
// transmitter as lowercase/uppercase ASCII hex, separated and broken into lines.
module mii_hex_streamer #(
  parameter int         DEPTH_LOG2     = 6,
  parameter int         BYTES_PER_LINE = 16,
  parameter bit         UPPERCASE      = 1'b0,
  parameter logic [7:0] SEP_CHAR       = 8'h20,
  parameter int         CNT_W          = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_rdy,
  input  logic [7:0]            in_d,
  input  logic                  in_eof,
  input  logic                  tx_active,
  output logic                  tx_dv,
  output logic [7:0]            tx_byte,
  output logic                  overflow,
  output logic [CNT_W-1:0]      drop_count,
  output logic [DEPTH_LOG2:0]   fifo_level,
  output logic                  busy
);

  localparam int                  DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] PTR_ONE  = 1;
  localparam logic [7:0]          LAST_COL = 8'(BYTES_PER_LINE - 1);

  typedef enum logic [2:0] {IDLE, HI, LO, SEP, CR, LF} state_t;

  state_t              state;
  logic                rdy_q;
  logic [DEPTH_LOG2:0] wr_ptr;
  logic [DEPTH_LOG2:0] rd_ptr;
  logic [8:0]          mem [DEPTH];
  logic [7:0]          byte_h;
  logic                eof_h;
  logic [7:0]          col;

  logic       wr_req;
  logic       fifo_empty;
  logic       fifo_full;
  logic       issue_ok;
  logic       pop;
  logic       wr_en;
  logic [8:0] head;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    if (n < 4'd10) return 8'h30 + {4'd0, n};
    return (UPPERCASE ? 8'h41 : 8'h61) + {4'd0, n} - 8'd10;
  endfunction

  assign wr_req     = in_rdy & ~rdy_q;
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                      (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);
  assign issue_ok   = ~tx_dv & ~tx_active;
  assign pop        = (state == IDLE) & ~fifo_empty & issue_ok;
  // A pop on the same edge frees a slot, so a write into a full FIFO is still legal.
  assign wr_en      = wr_req & (~fifo_full | pop);
  assign head       = mem[rd_ptr[DEPTH_LOG2-1:0]];
  assign fifo_level = wr_ptr - rd_ptr;
  assign busy       = (state != IDLE) | ~fifo_empty;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[DEPTH_LOG2-1:0]] <= {in_eof, in_d};
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rdy_q      <= 1'b0;
      wr_ptr     <= '0;
      overflow   <= 1'b0;
      drop_count <= '0;
    end else begin
      rdy_q <= in_rdy;
      if (wr_en) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end else if (wr_req) begin
        overflow <= 1'b1;
        if (drop_count != '1) drop_count <= drop_count + CNT_W'(1);
      end
    end
  end

  // Pops are gated on issue_ok, so the high digit normally goes out from IDLE;
  // HI only parks an already-popped byte until the UART can take it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      rd_ptr  <= '0;
      tx_dv   <= 1'b0;
      tx_byte <= 8'h00;
      byte_h  <= 8'h00;
      eof_h   <= 1'b0;
      col     <= 8'h00;
    end else begin
      tx_dv <= 1'b0;
      case (state)
        IDLE: if (pop) begin
          rd_ptr  <= rd_ptr + PTR_ONE;
          byte_h  <= head[7:0];
          eof_h   <= head[8];
          tx_byte <= hex_char(head[7:4]);
          tx_dv   <= 1'b1;
          state   <= LO;
        end
        HI: if (issue_ok) begin
          tx_byte <= hex_char(byte_h[7:4]);
          tx_dv   <= 1'b1;
          state   <= LO;
        end
        LO: if (issue_ok) begin
          tx_byte <= hex_char(byte_h[3:0]);
          tx_dv   <= 1'b1;
          if (eof_h || col == LAST_COL) begin
            col   <= 8'h00;
            state <= CR;
          end else begin
            col   <= col + 8'd1;
            state <= SEP;
          end
        end
        SEP: if (issue_ok) begin
          tx_byte <= SEP_CHAR;
          tx_dv   <= 1'b1;
          state   <= IDLE;
        end
        CR: if (issue_ok) begin
          tx_byte <= 8'h0D;
          tx_dv   <= 1'b1;
          state   <= LF;
        end
        LF: if (issue_ok) begin
          tx_byte <= 8'h0A;
          tx_dv   <= 1'b1;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mii_hex_streamer.sv
// Bench for mii_hex_streamer: two instances (lowercase/16 per line, uppercase/4 per line)
// share the MII stimulus; each has its own UART busy model and expected character stream.
module tb_mii_hex_streamer;

  localparam int DL2   = 4;
  localparam int DEPTH = 1 << DL2;
  localparam int BPL0  = 16;
  localparam int BPL1  = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           reset;
  logic           in_rdy;
  logic [7:0]     in_d;
  logic           in_eof;
  logic           tx_active0, tx_active1;
  logic           tx_dv0, tx_dv1;
  logic [7:0]     tx_byte0, tx_byte1;
  logic           overflow0, overflow1;
  logic [15:0]    drop0, drop1;
  logic [DL2:0]   level0, level1;
  logic           busy0, busy1;

  int n_cmp = 0;
  int n_bad = 0;

  mii_hex_streamer #(.DEPTH_LOG2(DL2), .BYTES_PER_LINE(BPL0), .UPPERCASE(1'b0)) dut0 (
    .clk(clk), .reset(reset), .in_rdy(in_rdy), .in_d(in_d), .in_eof(in_eof),
    .tx_active(tx_active0), .tx_dv(tx_dv0), .tx_byte(tx_byte0), .overflow(overflow0),
    .drop_count(drop0), .fifo_level(level0), .busy(busy0));

  mii_hex_streamer #(.DEPTH_LOG2(DL2), .BYTES_PER_LINE(BPL1), .UPPERCASE(1'b1)) dut1 (
    .clk(clk), .reset(reset), .in_rdy(in_rdy), .in_d(in_d), .in_eof(in_eof),
    .tx_active(tx_active1), .tx_dv(tx_dv1), .tx_byte(tx_byte1), .overflow(overflow1),
    .drop_count(drop1), .fifo_level(level1), .busy(busy1));

  // UART model: busy for ulen cycles after seeing a strobe, or forced busy by stall.
  bit stall = 1'b0;
  int ulen0 = 2, ulen1 = 3;
  int cnt0 = 0, cnt1 = 0;
  assign tx_active0 = stall | (cnt0 != 0);
  assign tx_active1 = stall | (cnt1 != 0);

  always @(posedge clk) begin
    if (tx_dv0) cnt0 <= ulen0; else if (cnt0 != 0) cnt0 <= cnt0 - 1;
    if (tx_dv1) cnt1 <= ulen1; else if (cnt1 != 0) cnt1 <= cnt1 - 1;
  end

  // Captured streams are kept as hex text so they can be compared and printed directly.
  string got0 = "", got1 = "", exp0 = "", exp1 = "";
  int    pulse_err = 0;
  logic  prev0 = 1'b0, prev1 = 1'b0;

  always @(negedge clk) begin
    if (tx_dv0) got0 <= {got0, $sformatf("%02x", tx_byte0)};
    if (tx_dv1) got1 <= {got1, $sformatf("%02x", tx_byte1)};
    if ((tx_dv0 && prev0) || (tx_dv1 && prev1)) pulse_err <= pulse_err + 1;
    prev0 <= tx_dv0;
    prev1 <= tx_dv1;
  end

  // Reference model: each byte is two hex digits, then CR LF if it ends a frame or
  // fills the line, otherwise the separator.
  int col0 = 0, col1 = 0;

  function automatic logic [7:0] asc(input logic [3:0] n, input bit up);
    if (n < 10) return 8'h30 + 8'(n);
    return (up ? 8'h41 : 8'h61) + 8'(n) - 8'd10;
  endfunction

  task automatic model_push(input logic [7:0] d, input logic eof);
    exp0 = {exp0, $sformatf("%02x%02x", asc(d[7:4], 1'b0), asc(d[3:0], 1'b0))};
    exp1 = {exp1, $sformatf("%02x%02x", asc(d[7:4], 1'b1), asc(d[3:0], 1'b1))};
    col0++;
    col1++;
    if (eof || col0 == BPL0) begin exp0 = {exp0, "0d0a"}; col0 = 0; end
    else exp0 = {exp0, "20"};
    if (eof || col1 == BPL1) begin exp1 = {exp1, "0d0a"}; col1 = 0; end
    else exp1 = {exp1, "20"};
  endtask

  task automatic clear_streams();
    exp0 = ""; exp1 = ""; got0 = ""; got1 = "";
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b0; in_rdy = 1'b0; stall = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    col0 = 0; col1 = 0;
    clear_streams();
  endtask

  task automatic push(input logic [7:0] d, input logic eof, input int hi, input int lo);
    @(negedge clk);
    in_rdy = 1'b1; in_d = d; in_eof = eof;
    repeat (hi) @(negedge clk);
    in_rdy = 1'b0; in_d = 8'($urandom); in_eof = 1'($urandom);
    repeat (lo - 1) @(negedge clk);
  endtask

  task automatic drain(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (!busy0 && !busy1 && !tx_dv0 && !tx_dv1 && !tx_active0 && !tx_active1) begin
        ok = 1'b1;
        break;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b0; in_rdy = 1'b0; in_d = 8'h00; in_eof = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({tx_dv0, tx_byte0, tx_dv1, tx_byte1} !== 18'h0) begin
      n_bad++; $display("FAIL reset_tx got %h required 0", {tx_dv0, tx_byte0, tx_dv1, tx_byte1});
    end
    n_cmp++;
    if ({overflow0, drop0, overflow1, drop1} !== 34'h0) begin
      n_bad++; $display("FAIL reset_drop got %h required 0", {overflow0, drop0, overflow1, drop1});
    end
    n_cmp++;
    if ({level0, busy0, level1, busy1} !== 12'h0) begin
      n_bad++; $display("FAIL reset_level got %h required 0", {level0, busy0, level1, busy1});
    end
    reset = 1'b1;
    clear_streams();
    $display("test_reset done");
  endtask

  task automatic test_single();
    bit ok;
    @(negedge clk);
    in_rdy = 1'b1; in_d = 8'hA5; in_eof = 1'b0;
    model_push(8'hA5, 1'b0);
    @(negedge clk);
    n_cmp++;
    if (tx_dv0 !== 1'b0 || level0 !== 5'd1) begin
      n_bad++; $display("FAIL single_e0 got dv=%b lvl=%0d required dv=0 lvl=1", tx_dv0, level0);
    end
    in_rdy = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (tx_dv0 !== 1'b1 || tx_byte0 !== 8'h61 || tx_byte1 !== 8'h41 || level0 !== 5'd0) begin
      n_bad++;
      $display("FAIL single_e1 got dv=%b b0=%h b1=%h lvl=%0d required dv=1 b0=61 b1=41 lvl=0",
               tx_dv0, tx_byte0, tx_byte1, level0);
    end
    @(negedge clk);
    n_cmp++;
    if (tx_dv0 !== 1'b0) begin
      n_bad++; $display("FAIL single_pulse got dv=%b required 0", tx_dv0);
    end
    drain(ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL single_drain timed out"); end
    n_cmp++;
    if (got0 != exp0) begin n_bad++; $display("FAIL single_s0 got %s required %s", got0, exp0); end
    n_cmp++;
    if (got1 != exp1) begin n_bad++; $display("FAIL single_s1 got %s required %s", got1, exp1); end
    n_cmp++;
    if (drop0 !== 16'd0 || overflow0 !== 1'b0) begin
      n_bad++; $display("FAIL single_drop got %0d/%b required 0/0", drop0, overflow0);
    end
    $display("test_single byte=a5 s0=%s s1=%s", got0, got1);
    clear_streams();
  endtask

  task automatic test_eof_line();
    bit ok;
    push(8'h3C, 1'b1, 1, 2);
    model_push(8'h3C, 1'b1);
    for (int i = 0; i < 4; i++) begin
      push(8'(8'h11 + i), 1'b0, 1 + (i % 2), 1);
      model_push(8'(8'h11 + i), 1'b0);
    end
    drain(ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL eof_drain timed out"); end
    n_cmp++;
    if (got0 != exp0) begin n_bad++; $display("FAIL eof_s0 got %s required %s", got0, exp0); end
    n_cmp++;
    if (got1 != exp1) begin n_bad++; $display("FAIL eof_s1 got %s required %s", got1, exp1); end
    $display("test_eof_line s1=%s", got1);
    clear_streams();
  endtask

  task automatic test_line_wrap();
    bit ok;
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      push(8'(i), 1'b0, $urandom_range(1, 2), $urandom_range(1, 3));
      model_push(8'(i), 1'b0);
    end
    drain(ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL wrap_drain timed out"); end
    n_cmp++;
    if (got1 != "30302030312030322030330d0a303420303520") begin
      n_bad++; $display("FAIL wrap_s1 got %s required 30302030312030322030330d0a303420303520", got1);
    end
    n_cmp++;
    if (got0 != exp0) begin n_bad++; $display("FAIL wrap_s0 got %s required %s", got0, exp0); end
    $display("test_line_wrap s1=%s", got1);
    clear_streams();
  endtask

  task automatic test_overflow();
    bit ok;
    logic [7:0] d;
    logic e;
    @(negedge clk);
    stall = 1'b1;
    for (int i = 0; i < DEPTH + 3; i++) begin
      d = 8'($urandom);
      e = ($urandom_range(0, 5) == 0);
      push(d, e, 1, 1);
      if (i < DEPTH) model_push(d, e);
    end
    @(negedge clk);
    n_cmp++;
    if (level0 !== 5'(DEPTH) || level1 !== 5'(DEPTH)) begin
      n_bad++; $display("FAIL ovf_level got %0d/%0d required %0d", level0, level1, DEPTH);
    end
    n_cmp++;
    if (overflow0 !== 1'b1 || overflow1 !== 1'b1) begin
      n_bad++; $display("FAIL ovf_flag got %b/%b required 1", overflow0, overflow1);
    end
    n_cmp++;
    if (drop0 !== 16'd3 || drop1 !== 16'd3) begin
      n_bad++; $display("FAIL ovf_count got %0d/%0d required 3", drop0, drop1);
    end
    stall = 1'b0;
    drain(ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL ovf_drain timed out"); end
    n_cmp++;
    if (got0 != exp0) begin n_bad++; $display("FAIL ovf_s0 got %s required %s", got0, exp0); end
    n_cmp++;
    if (got1 != exp1) begin n_bad++; $display("FAIL ovf_s1 got %s required %s", got1, exp1); end
    $display("test_overflow pushed=%0d dropped=%0d", DEPTH + 3, drop0);
    clear_streams();
  endtask

  task automatic test_held_rdy();
    bit ok;
    logic [7:0] first;
    first = 8'($urandom);
    @(negedge clk);
    in_rdy = 1'b1; in_d = first; in_eof = 1'b0;
    model_push(first, 1'b0);
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      in_d = 8'($urandom);
    end
    @(negedge clk);
    in_rdy = 1'b0;
    drain(ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL held_drain timed out"); end
    n_cmp++;
    if (got0 != exp0) begin n_bad++; $display("FAIL held_s0 got %s required %s", got0, exp0); end
    n_cmp++;
    if (got1 != exp1) begin n_bad++; $display("FAIL held_s1 got %s required %s", got1, exp1); end
    $display("test_held_rdy first=%h s0=%s", first, got0);
    clear_streams();
  endtask

  task automatic test_reset_mid_line();
    bit ok;
    bit seen;
    push(8'h5A, 1'b1, 1, 1);
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (tx_dv1 && tx_byte1 == 8'h0D) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    n_cmp++;
    if (!seen) begin n_bad++; $display("FAIL midline_cr no CR observed"); end
    reset = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (tx_dv0 !== 1'b0 || tx_dv1 !== 1'b0) begin
      n_bad++; $display("FAIL midline_dv got %b/%b required 0", tx_dv0, tx_dv1);
    end
    n_cmp++;
    if (level0 !== 5'd0 || level1 !== 5'd0 || overflow0 !== 1'b0 || overflow1 !== 1'b0 ||
        drop0 !== 16'd0 || drop1 !== 16'd0) begin
      n_bad++;
      $display("FAIL midline_state got lvl=%0d/%0d ovf=%b/%b drop=%0d/%0d required all 0",
               level0, level1, overflow0, overflow1, drop0, drop1);
    end
    @(negedge clk);
    reset = 1'b1;
    col0 = 0; col1 = 0;
    clear_streams();
    push(8'hB7, 1'b0, 1, 1);
    model_push(8'hB7, 1'b0);
    drain(ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL midline_drain timed out"); end
    n_cmp++;
    if (got0 != exp0) begin n_bad++; $display("FAIL midline_s0 got %s required %s", got0, exp0); end
    n_cmp++;
    if (got1 != exp1) begin n_bad++; $display("FAIL midline_s1 got %s required %s", got1, exp1); end
    $display("test_reset_mid_line s0=%s s1=%s", got0, got1);
    clear_streams();
  endtask

  task automatic test_random();
    bit ok;
    logic [7:0] d;
    logic e;
    for (int b = 0; b < 4; b++) begin
      ulen0 = $urandom_range(1, 5);
      ulen1 = $urandom_range(1, 5);
      for (int i = 0; i < 10; i++) begin
        d = 8'($urandom);
        e = ($urandom_range(0, 5) == 0);
        push(d, e, $urandom_range(1, 3), $urandom_range(1, 4));
        model_push(d, e);
      end
      drain(ok);
      n_cmp++;
      if (!ok) begin n_bad++; $display("FAIL rand_drain batch %0d timed out", b); end
      n_cmp++;
      if (got0 != exp0) begin n_bad++; $display("FAIL rand_s0 batch %0d got %s required %s", b, got0, exp0); end
      n_cmp++;
      if (got1 != exp1) begin n_bad++; $display("FAIL rand_s1 batch %0d got %s required %s", b, got1, exp1); end
      $display("test_random batch %0d ulen=%0d/%0d chars=%0d/%0d", b, ulen0, ulen1,
               got0.len() / 2, got1.len() / 2);
      clear_streams();
    end
    n_cmp++;
    if (pulse_err != 0) begin n_bad++; $display("FAIL tx_dv_width got %0d long pulses required 0", pulse_err); end
  endtask

  initial begin
    reset = 1'b0; in_rdy = 1'b0; in_d = 8'h00; in_eof = 1'b0;
    test_reset();
    test_single();
    test_eof_line();
    test_line_wrap();
    test_random();
    test_held_rdy();
    test_overflow();
    test_reset_mid_line();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
